// File: rtl/aes_cipher_iter.sv
// Iterative AES-128 encryption core: one round per clock, expanded key supplied on a flat bus.
// Optional AES_ABORT_EN adds an `abort` input that cancels an in-flight block.
module aes_cipher_iter #(
    parameter int unsigned NR      = 10,
    parameter int unsigned KEY_BUS = (NR + 1) * 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
`ifdef AES_ABORT_EN
    input  logic               abort,
`endif
    input  logic [127:0]       plaintext,
    input  logic [KEY_BUS-1:0] round_key,
    output logic               busy,
    output logic               done,
    output logic [127:0]       ciphertext
);

    localparam int unsigned CTR_W = 4;
    localparam int unsigned BLK_W = 128;
    localparam int unsigned RK_N  = 16;
    localparam logic [CTR_W-1:0] LAST_RND = CTR_W'(NR);

    // FIPS-197 S-box, entry 0 in the most significant byte
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [CTR_W-1:0] ctr_q, ctr_d;
    logic [BLK_W-1:0] st_q, st_d;
    logic [BLK_W-1:0] ct_d;
    logic             busy_d, done_d;
    logic [BLK_W-1:0] rk [RK_N];
    logic [BLK_W-1:0] sb_sr;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TBL[{~b, 3'b111} -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes then ShiftRows; byte i sits at row i%4, column i/4
    function automatic logic [BLK_W-1:0] sub_shift(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                y[127 - 8*(4*c + r) -: 8] = sbox(x[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
        return y;
    endfunction

    function automatic logic [BLK_W-1:0] mix_columns(input logic [BLK_W-1:0] x);
        logic [BLK_W-1:0] y;
        logic [7:0] a0, a1, a2, a3;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127 - 32*c -: 8];
            a1 = x[119 - 32*c -: 8];
            a2 = x[111 - 32*c -: 8];
            a3 = x[103 - 32*c -: 8];
            y[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            y[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            y[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            y[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return y;
    endfunction

    // Round keys indexed directly by the 4-bit counter; unused slots read as zero
    always_comb begin
        for (int k = 0; k < int'(RK_N); k++) begin
            rk[k] = '0;
        end
        for (int k = 0; k <= int'(NR); k++) begin
            rk[k] = round_key[128*k +: 128];
        end
    end

    assign sb_sr = sub_shift(st_q);

    always_comb begin
        fsm_d  = fsm_q;
        ctr_d  = ctr_q;
        st_d   = st_q;
        ct_d   = ciphertext;
        busy_d = busy;
        done_d = 1'b0;
        case (fsm_q)
            IDLE: begin
                if (start) begin
                    st_d   = plaintext ^ rk[0];
                    ctr_d  = CTR_W'(1);
                    busy_d = 1'b1;
                    fsm_d  = RUN;
                end
            end
            RUN: begin
`ifdef AES_ABORT_EN
                if (abort) begin
                    fsm_d  = IDLE;
                    st_d   = '0;
                    ctr_d  = '0;
                    busy_d = 1'b0;
                end else
`endif
                if (ctr_q == '0 || ctr_q > LAST_RND) begin
                    fsm_d  = IDLE;
                    ctr_d  = '0;
                    busy_d = 1'b0;
                end else if (ctr_q == LAST_RND) begin
                    ct_d   = sb_sr ^ rk[ctr_q];
                    done_d = 1'b1;
                    busy_d = 1'b0;
                    ctr_d  = '0;
                    fsm_d  = IDLE;
                end else begin
                    st_d  = mix_columns(sb_sr) ^ rk[ctr_q];
                    ctr_d = ctr_q + CTR_W'(1);
                end
            end
            default: begin
                fsm_d  = IDLE;
                ctr_d  = '0;
                busy_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q      <= IDLE;
            ctr_q      <= '0;
            st_q       <= '0;
            ciphertext <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            fsm_q      <= fsm_d;
            ctr_q      <= ctr_d;
            st_q       <= st_d;
            ciphertext <= ct_d;
            busy       <= busy_d;
            done       <= done_d;
        end
    end

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Bench for aes_cipher_iter: byte-array AES-128 model with a field-arithmetic S-box and its own key expansion.
module tb_aes_cipher_iter;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           start;
    logic [127:0]   plaintext;
    logic [1407:0]  round_key;
    logic           busy;
    logic           done;
    logic [127:0]   ciphertext;
`ifdef AES_ABORT_EN
    logic           abort;
`endif

    int checks   = 0;
    int failures = 0;
    logic [7:0] sbox_m [256];

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_cipher_iter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
`ifdef AES_ABORT_EN
        .abort      (abort),
`endif
        .plaintext  (plaintext),
        .round_key  (round_key),
        .busy       (busy),
        .done       (done),
        .ciphertext (ciphertext)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_m[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [1407:0] expand_key(input logic [127:0] key);
        logic [31:0]   w [44];
        logic [31:0]   t;
        logic [7:0]    rcon;
        logic [1407:0] bus;
        rcon = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]} ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        bus = '0;
        for (int k = 0; k <= 10; k++) bus[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return bus;
    endfunction

    function automatic logic [127:0] encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [1407:0] rk;
        logic [7:0]    s [16];
        logic [7:0]    t [16];
        logic [7:0]    a0, a1, a2, a3;
        logic [127:0]  out;
        rk = expand_key(key);
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[127 - 8*i -: 8];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    s[row + 4*c] = t[row + 4*((c + row) % 4)];
            if (r < 10) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[128*r + 127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
        return out;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one block and wait for done; lat counts edges including the sampling edge, -1 on timeout
    task automatic do_block(input logic [127:0] key, input logic [127:0] pt,
                            output int lat, output logic [127:0] ct_o);
        round_key = expand_key(key);
        plaintext = pt;
        start = 1'b1;
        tick();
        start = 1'b0;
        plaintext = rand128();
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        ct_o = ciphertext;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; plaintext = '0; round_key = '0;
`ifdef AES_ABORT_EN
        abort = 1'b0;
`endif
        tick(); tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (ciphertext !== 128'h0) begin failures++; $display("FAIL reset_ct: got %h expected 0", ciphertext); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_fips_vectors();
        int lat;
        logic [127:0] ct;
        do_block(KEY_B, PT_B, lat, ct);
        checks++; if (lat != 11) begin failures++; $display("FAIL appb_latency: got %0d expected 11", lat); end
        checks++; if (ct !== CT_B) begin failures++; $display("FAIL appb_ct: got %h expected %h", ct, CT_B); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL appb_busy_at_done: got %b expected 0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL appb_done_width: got %b expected 0", done); end
        checks++; if (ciphertext !== CT_B) begin failures++; $display("FAIL appb_ct_hold: got %h expected %h", ciphertext, CT_B); end
        do_block(KEY_C, PT_C, lat, ct);
        checks++; if (lat != 11) begin failures++; $display("FAIL c1_latency: got %0d expected 11", lat); end
        checks++; if (ct !== CT_C) begin failures++; $display("FAIL c1_ct: got %h expected %h", ct, CT_C); end
        tick();
    endtask

    task automatic test_random();
        int lat;
        logic [127:0] key, pt, ct, exp_ct;
        for (int n = 0; n < 12; n++) begin
            key = rand128();
            pt  = rand128();
            exp_ct = encrypt(key, pt);
            do_block(key, pt, lat, ct);
            checks++; if (lat != 11) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected 11", n, lat); end
            checks++; if (ct !== exp_ct) begin failures++; $display("FAIL rand_ct[%0d]: got %h expected %h", n, ct, exp_ct); end
            repeat ($urandom_range(0, 3)) tick();
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        round_key = expand_key(KEY_B);
        plaintext = PT_B;
        start = 1'b1;
        tick();
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
        checks++; if (lat != 11) begin failures++; $display("FAIL b2b_first_latency: got %0d expected 11", lat); end
        checks++; if (ciphertext !== CT_B) begin failures++; $display("FAIL b2b_first_ct: got %h expected %h", ciphertext, CT_B); end
        round_key = expand_key(KEY_C);
        plaintext = PT_C;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_no_gap_busy: got %b expected 1", busy); end
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
        checks++; if (lat != 10) begin failures++; $display("FAIL b2b_done_spacing: got %0d expected 11", lat + 1); end
        checks++; if (ciphertext !== CT_C) begin failures++; $display("FAIL b2b_second_ct: got %h expected %h", ciphertext, CT_C); end
        tick();
    endtask

    task automatic test_start_while_busy();
        int ndone;
        logic [127:0] key, pt_a, ct_seen, exp_ct;
        key = rand128();
        pt_a = rand128();
        exp_ct = encrypt(key, pt_a);
        round_key = expand_key(key);
        plaintext = pt_a;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        plaintext = rand128();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL swb_busy: got %b expected 1", busy); end
        ndone = 0;
        ct_seen = '0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done === 1'b1) begin ndone++; ct_seen = ciphertext; end
        end
        checks++; if (ndone != 1) begin failures++; $display("FAIL swb_done_count: got %0d expected 1", ndone); end
        checks++; if (ct_seen !== exp_ct) begin failures++; $display("FAIL swb_ct: got %h expected %h", ct_seen, exp_ct); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL swb_idle_after: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid();
        int lat;
        logic [127:0] key, pt, ct, exp_ct;
        round_key = expand_key(rand128());
        plaintext = rand128();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %b expected 0", done); end
        checks++; if (ciphertext !== 128'h0) begin failures++; $display("FAIL rstmid_ct: got %h expected 0", ciphertext); end
        tick();
        rst_n = 1'b1;
        tick();
        key = rand128();
        pt = rand128();
        exp_ct = encrypt(key, pt);
        do_block(key, pt, lat, ct);
        checks++; if (lat != 11) begin failures++; $display("FAIL rstmid_after_latency: got %0d expected 11", lat); end
        checks++; if (ct !== exp_ct) begin failures++; $display("FAIL rstmid_after_ct: got %h expected %h", ct, exp_ct); end
        tick();
    endtask

`ifdef AES_ABORT_EN
    task automatic test_abort();
        int lat, ndone;
        logic [127:0] key, pt, ct, prev_ct, exp_ct;
        key = rand128();
        pt = rand128();
        prev_ct = encrypt(key, pt);
        do_block(key, pt, lat, ct);
        checks++; if (ct !== prev_ct) begin failures++; $display("FAIL abort_pre_ct: got %h expected %h", ct, prev_ct); end
        tick();
        round_key = expand_key(rand128());
        plaintext = rand128();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy: got %b expected 0", busy); end
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            if (done === 1'b1) ndone++;
            tick();
        end
        checks++; if (ndone != 0) begin failures++; $display("FAIL abort_no_done: got %0d expected 0", ndone); end
        checks++; if (ciphertext !== prev_ct) begin failures++; $display("FAIL abort_ct_kept: got %h expected %h", ciphertext, prev_ct); end
        key = rand128();
        pt = rand128();
        exp_ct = encrypt(key, pt);
        round_key = expand_key(key);
        plaintext = pt;
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
        checks++; if (lat != 11) begin failures++; $display("FAIL abort_start_wins_latency: got %0d expected 11", lat); end
        checks++; if (ciphertext !== exp_ct) begin failures++; $display("FAIL abort_start_wins_ct: got %h expected %h", ciphertext, exp_ct); end
        tick();
    endtask
`endif

    initial begin
        build_sbox();
        test_reset();
        test_fips_vectors();
        test_random();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid();
`ifdef AES_ABORT_EN
        test_abort();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
